// File: rtl/sync_raster_counter_pkg.sv
// Shared constants and types for the sync-driven raster counter.
package sync_raster_pkg;

  // Axis behaviour when the terminal count is reached.
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_WRAP    = 1'b1;

  // Per-cycle action chosen for one axis.
  typedef enum logic [2:0] {
    AXIS_HOLD  = 3'd0,  // no change this cycle
    AXIS_CLEAR = 3'd1,  // restart: count and done return to 0
    AXIS_STEP  = 3'd2,  // count below limit: advance by one
    AXIS_WRAP  = 3'd3,  // at/over limit in wrap mode: back to 0, pulse wrap
    AXIS_STOP  = 3'd4   // at/over limit in one-shot mode: freeze, set done
  } axis_action_e;

endpackage

// File: rtl/sync_raster_counter_axis.sv
// One raster axis: bounded counter with restart, one-shot stop or wrap.
module axis_counter
  import sync_raster_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] cnt,
  output logic             done,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  axis_action_e     action_s;

  // Select this cycle's action; restart beats counting, and a stopped axis ignores inc.
  always_comb begin
    action_s = AXIS_HOLD;
    if (clr) begin
      action_s = AXIS_CLEAR;
    end else if (inc && !done_q) begin
      // Live >= compare so a limit lowered below the count still terminates.
      if (cnt_q >= limit) begin
        if (wrap_mode == MODE_WRAP) begin
          action_s = AXIS_WRAP;
        end else begin
          action_s = AXIS_STOP;
        end
      end else begin
        action_s = AXIS_STEP;
      end
    end else begin
      action_s = AXIS_HOLD;
    end
  end

  // Turn the selected action into next-state values; wrap is a single-cycle pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    wrap_d = 1'b0;
    case (action_s)
      AXIS_CLEAR: begin
        cnt_d  = {WIDTH{1'b0}};
        done_d = 1'b0;
      end
      AXIS_STEP: begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      AXIS_WRAP: begin
        cnt_d  = {WIDTH{1'b0}};
        wrap_d = 1'b1;
      end
      AXIS_STOP: begin
        done_d = 1'b1;
      end
      AXIS_HOLD: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d  = {WIDTH{1'b0}};
        done_d = 1'b0;
        wrap_d = 1'b0;
      end
    endcase
  end

  // Axis state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {WIDTH{1'b0}};
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/sync_raster_counter.sv
// Raster position counter: pixel axis restarted by HSYNC, line axis advanced
// by HSYNC and restarted by VSYNC. All outputs come straight from registers.
module sync_raster_counter
  import sync_raster_pkg::*;
#(
  parameter int XW = 8,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          en,
  input  logic          wrap_mode,
  input  logic [XW-1:0] x_limit,
  input  logic [YW-1:0] y_limit,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          x_done,
  output logic          y_done,
  output logic          x_wrap,
  output logic          y_wrap
);

  logic hsync_q;
  logic vsync_q;
  logic hsync_rise_s;
  logic vsync_rise_s;
  logic x_clr_s;
  logic x_inc_s;
  logic y_clr_s;
  logic y_inc_s;

  // Previous sync levels, so a held level yields exactly one restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
    end
  end

  assign hsync_rise_s = hsync & ~hsync_q;
  assign vsync_rise_s = vsync & ~vsync_q;

  // A frame start restarts both axes; a line start restarts only the pixel
  // axis and steps the line axis, unless it coincides with a frame start.
  assign x_clr_s = vsync_rise_s | hsync_rise_s;
  assign x_inc_s = en;
  assign y_clr_s = vsync_rise_s;
  assign y_inc_s = hsync_rise_s & ~vsync_rise_s;

  axis_counter #(
    .WIDTH (XW)
  ) u_x_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (x_clr_s),
    .inc       (x_inc_s),
    .limit     (x_limit),
    .wrap_mode (wrap_mode),
    .cnt       (x_cnt),
    .done      (x_done),
    .wrap      (x_wrap)
  );

  axis_counter #(
    .WIDTH (YW)
  ) u_y_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (y_clr_s),
    .inc       (y_inc_s),
    .limit     (y_limit),
    .wrap_mode (wrap_mode),
    .cnt       (y_cnt),
    .done      (y_done),
    .wrap      (y_wrap)
  );

endmodule
